// File: rtl/phy_pkg.sv
// Shared definitions for the PHY receive path: idle comma, lane count,
// and the byte-aligner state encoding.
package phy_pkg;

    localparam logic [7:0]  COMMA     = 8'hBC;
    localparam int unsigned NUM_LANES = 4;

    // 2'd3 is unused; the aligner treats it as illegal and returns to SEARCH
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/phy_rx_byte_aligner.sv
// Serial byte aligner: hunts for the comma bit-by-bit, confirms alignment
// over LOCK_COUNT consecutive byte-spaced commas, then emits one byte per
// eight bit clocks while locked.
module phy_rx_byte_aligner #(
    parameter logic [7:0]  COMMA      = phy_pkg::COMMA,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       locked
);
    import phy_pkg::*;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    rx_state_t  state, state_nxt;
    logic [7:0] sr;
    logic [7:0] w;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [3:0] comma_cnt, comma_cnt_nxt;
    logic       is_comma;
    logic       byte_end;

    assign w         = {sr[6:0], data_in};
    assign is_comma  = (w == COMMA);
    assign byte_end  = (bit_cnt == 3'd7);
    assign byte_data = w;
    assign locked    = (state == ACTIVE);

    // Next-state logic for the alignment FSM and its counters
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt + 3'd1;
        comma_cnt_nxt = comma_cnt;
        byte_done     = 1'b0;
        case (state)
            SEARCH: begin
                bit_cnt_nxt = '0;
                if (is_comma) begin
                    comma_cnt_nxt = 4'd1;
                    state_nxt     = ALIGN;
                end
            end
            ALIGN: begin
                if (byte_end) begin
                    if (is_comma) begin
                        comma_cnt_nxt = comma_cnt + 4'd1;
                        if (comma_cnt + 4'd1 == LOCK_CNT) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        comma_cnt_nxt = '0;
                        state_nxt     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                byte_done = byte_end;
            end
            default: begin
                state_nxt     = SEARCH;
                bit_cnt_nxt   = '0;
                comma_cnt_nxt = '0;
            end
        endcase
    end

    // State, counter and shift-register updates
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sr        <= w;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
        end
    end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Receive deserializer: aligns the serial stream on the idle comma, then
// distributes bytes round-robin over four lanes and publishes a frame of
// four lane bytes with per-lane valids once lane 3 completes.
module phy_rx_deserializer #(
    parameter logic [7:0]  COMMA      = phy_pkg::COMMA,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic       recirculacion,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       frame_strobe
);
    import phy_pkg::*;

    localparam logic [1:0] LAST_LANE = 2'(NUM_LANES - 1);

    logic [7:0] byte_data;
    logic       byte_done;
    logic       locked;
    logic       byte_valid;
    logic [1:0] lane_idx;
    logic [7:0] lane_buf0, lane_buf1, lane_buf2;
    logic       vbuf0, vbuf1, vbuf2;

    phy_rx_byte_aligner #(
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_aligner (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .locked    (locked)
    );

    assign byte_valid    = (byte_data != COMMA);
    assign recirculacion = locked;

    // Lane demux: buffer lanes 0..2, publish the whole frame on lane 3
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            lane_idx     <= '0;
            lane_buf0    <= '0;
            lane_buf1    <= '0;
            lane_buf2    <= '0;
            vbuf0        <= 1'b0;
            vbuf1        <= 1'b0;
            vbuf2        <= 1'b0;
            data_out0    <= '0;
            data_out1    <= '0;
            data_out2    <= '0;
            data_out3    <= '0;
            valid_out0   <= 1'b0;
            valid_out1   <= 1'b0;
            valid_out2   <= 1'b0;
            valid_out3   <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (!locked) begin
                lane_idx <= '0;
            end else if (byte_done) begin
                lane_idx <= lane_idx + 2'd1;
                case (lane_idx)
                    2'd0: begin
                        lane_buf0 <= byte_data;
                        vbuf0     <= byte_valid;
                    end
                    2'd1: begin
                        lane_buf1 <= byte_data;
                        vbuf1     <= byte_valid;
                    end
                    2'd2: begin
                        lane_buf2 <= byte_data;
                        vbuf2     <= byte_valid;
                    end
                    default: begin
                        lane_buf0 <= lane_buf0;
                    end
                endcase
                if (lane_idx == LAST_LANE) begin
                    data_out0    <= lane_buf0;
                    data_out1    <= lane_buf1;
                    data_out2    <= lane_buf2;
                    data_out3    <= byte_data;
                    valid_out0   <= vbuf0;
                    valid_out1   <= vbuf1;
                    valid_out2   <= vbuf2;
                    valid_out3   <= byte_valid;
                    frame_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Testbench for phy_rx_deserializer: directed sequences plus random frames,
// every bit checked against a stream-position model of lock and framing.
module tb_phy_rx_deserializer;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;

    logic       clk_32f = 1'b0;
    logic       clk_run = 1'b1;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic       recirculacion;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       frame_strobe;

    int tests  = 0;
    int failed = 0;

    // model state: positions are 1-based bit counts since reset
    logic [7:0]  win;
    int          n;
    int          match_pos;
    int          lock_pos;
    logic [7:0]  pend [4];
    logic [31:0] exp_data;
    logic [3:0]  exp_valid;
    logic        exp_strobe;
    logic        exp_lock;

    phy_rx_deserializer #(
        .COMMA      (BC),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .data_in       (data_in),
        .recirculacion (recirculacion),
        .data_out0     (data_out0),
        .data_out1     (data_out1),
        .data_out2     (data_out2),
        .data_out3     (data_out3),
        .valid_out0    (valid_out0),
        .valid_out1    (valid_out1),
        .valid_out2    (valid_out2),
        .valid_out3    (valid_out3),
        .frame_strobe  (frame_strobe)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk_32f = ~clk_32f;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        win = '0; n = 0; match_pos = -1; lock_pos = -1;
        for (int i = 0; i < 4; i++) pend[i] = '0;
        exp_data = '0; exp_valid = '0; exp_strobe = 1'b0; exp_lock = 1'b0;
    endfunction

    // Lock = LOCK commas spaced exactly 8 bits apart starting at a bitwise
    // match; afterwards every 8th bit ends a byte, every 4th byte a frame.
    function automatic void model_step(input logic b);
        int k;
        win = {win[6:0], b};
        n++;
        exp_strobe = 1'b0;
        if (lock_pos < 0) begin
            if (match_pos < 0) begin
                if (win == BC) match_pos = n;
            end else if ((n - match_pos) % 8 == 0) begin
                if (win != BC) match_pos = -1;
                else if ((n - match_pos) / 8 + 1 == LOCK) lock_pos = n;
            end
        end else if ((n - lock_pos) % 8 == 0) begin
            k = (n - lock_pos) / 8 - 1;
            pend[k % 4] = win;
            if (k % 4 == 3) begin
                exp_data   = {pend[0], pend[1], pend[2], pend[3]};
                exp_valid  = {pend[0] != BC, pend[1] != BC, pend[2] != BC, pend[3] != BC};
                exp_strobe = 1'b1;
            end
        end
        exp_lock = (lock_pos >= 0);
    endfunction

    task automatic check_outputs();
        check("recirculacion", 32'(recirculacion), 32'(exp_lock));
        check("frame_strobe", 32'(frame_strobe), 32'(exp_strobe));
        check("data_out", {data_out0, data_out1, data_out2, data_out3}, exp_data);
        check("valid_out", 32'({valid_out0, valid_out1, valid_out2, valid_out3}), 32'(exp_valid));
    endtask

    task automatic check_zero(input string tag);
        check(tag, {data_out0, data_out1, data_out2, data_out3}, 32'h0);
        check(tag, 32'({recirculacion, frame_strobe, valid_out0, valid_out1, valid_out2, valid_out3}), 32'h0);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_step(b);
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Synchronous-looking pulse with clock running
    task automatic reset_pulse();
        @(negedge clk_32f);
        reset = 1'b1;
        #1;
        check_zero("reset_running_immediate");
        @(posedge clk_32f);
        #1;
        check_zero("reset_running_held");
        @(negedge clk_32f);
        reset = 1'b0;
        model_reset();
    endtask

    // Reset asserted while the clock is parked low
    task automatic reset_no_clock();
        @(negedge clk_32f);
        clk_run = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_zero("reset_stopped_immediate");
        #20;
        check_zero("reset_stopped_held");
        clk_run = 1'b1;
        @(negedge clk_32f);
        reset = 1'b0;
        model_reset();
    endtask

    logic [7:0] rb;

    initial begin
        model_reset();
        #12;
        check_zero("reset_initial");
        @(negedge clk_32f);
        reset = 1'b0;

        // junk 101 then four commas: lock on the 35th bit
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_byte(BC);
        for (int i = 7; i >= 1; i--) send_bit(BC[i]);
        check("lock_before_bit35", 32'(recirculacion), 32'h0);
        send_bit(BC[0]);
        check("lock_at_bit35", 32'(recirculacion), 32'h1);

        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("frame1_strobe", 32'(frame_strobe), 32'h1);
        check("frame1_data", {data_out0, data_out1, data_out2, data_out3}, 32'h11223344);
        check("frame1_valid", 32'({valid_out0, valid_out1, valid_out2, valid_out3}), 32'hF);

        send_byte(BC); send_byte(8'hAA); send_byte(BC); send_byte(8'h0F);
        check("frame2_data", {data_out0, data_out1, data_out2, data_out3}, 32'hBCAABC0F);
        check("frame2_valid", 32'({valid_out0, valid_out1, valid_out2, valid_out3}), 32'h5);

        // three random frames, one payload byte forced to the comma
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < 4; l++) begin
                rb = 8'($urandom_range(0, 255));
                if (f == 1 && l == 2) rb = BC;
                send_byte(rb);
            end
            check("random_frame_strobe", 32'(frame_strobe), 32'h1);
        end
        check("lock_sticky_after_payload_comma", 32'(recirculacion), 32'h1);

        // reset with clock stopped, then broken comma run
        send_bit(1'b1); send_bit(1'b0);
        reset_no_clock();
        for (int i = 0; i < 3; i++) send_byte(BC);
        send_byte(8'h55);
        check("no_lock_after_broken_run", 32'(recirculacion), 32'h0);
        for (int i = 0; i < 3; i++) send_byte(BC);
        check("no_lock_three_commas", 32'(recirculacion), 32'h0);
        send_byte(BC);
        check("relock_after_four", 32'(recirculacion), 32'h1);
        send_byte(BC); send_byte(8'hAA); send_byte(BC); send_byte(8'h0F);
        check("frame3_valid", 32'({valid_out0, valid_out1, valid_out2, valid_out3}), 32'h5);

        // reset pulse in the middle of the lane 2 byte
        send_byte(8'hC3); send_byte(8'h3C);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        reset_pulse();
        check("lock_cleared_by_pulse", 32'(recirculacion), 32'h0);
        for (int i = 0; i < 4; i++) send_byte(BC);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("relock_frame_data", {data_out0, data_out1, data_out2, data_out3}, 32'h01020304);
        check("relock_frame_valid", 32'({valid_out0, valid_out1, valid_out2, valid_out3}), 32'hF);

        // a few idle bits to confirm outputs hold between strobes
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
